// File: rtl/lcd_capture_pkg.sv
// Shared definitions for the LCD capture block: default panel geometry and the
// capture state encoding.
package lcd_capture_pkg;

   localparam int LCD_WIDTH  = 160;
   localparam int LCD_HEIGHT = 144;

   typedef enum logic [1:0] {
      SYNC_WAIT = 2'd0,
      ACTIVE    = 2'd1,
      BLANK     = 2'd2
   } lcd_state_e;

endpackage

// File: rtl/lcd_capture_sync_edge.sv
// Registered rising-edge detector (sync_edge), used for both hsync and vsync.
// Ports:
//   clock  in  system clock
//   reset  in  synchronous, active-high reset
//   sig    in  level input
//   rise   out high for the cycle where sig is 1 and was 0 on the previous clock
module lcd_capture_sync_edge (
   input  logic clock,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic prev;

   always_ff @(posedge clock) begin
      if (reset) prev <= 1'b0;
      else       prev <= sig;
   end

   assign rise = sig & ~prev;

endmodule

// File: rtl/lcd_capture.sv
// Game Boy video stream receiver. Samples 2-bit pixels, tracks x/y from the
// sync pulses, packs 4 pixels per byte (first pixel in bits [7:6]) and writes
// each byte to a framebuffer RAM port.
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   pixel_data[1:0]       pixel value, valid while pixel_latch=1
//   pixel_latch           one pixel accepted per cycle high
//   hsync / vsync         rising edge ends the current line / frame
//   fb_A[15:0], fb_Do[7:0], fb_wr_n, fb_cs_n   framebuffer write port
//   frame_done, line_err, frame_err            1-cycle status pulses
//   cur_line[7:0]         current line y (debug)
module lcd_capture
   import lcd_capture_pkg::*;
#(
   parameter int          WIDTH   = LCD_WIDTH,
   parameter int          HEIGHT  = LCD_HEIGHT,
   parameter logic [15:0] FB_BASE = 16'h0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  pixel_data,
   input  logic        pixel_latch,
   input  logic        hsync,
   input  logic        vsync,
   output logic [15:0] fb_A,
   output logic [7:0]  fb_Do,
   output logic        fb_wr_n,
   output logic        fb_cs_n,
   output logic        frame_done,
   output logic        line_err,
   output logic        frame_err,
   output logic [7:0]  cur_line
);

   localparam logic [7:0]  WIDTH_X  = 8'(WIDTH);
   localparam logic [7:0]  HEIGHT_Y = 8'(HEIGHT);
   localparam logic [15:0] LINE_B   = 16'(WIDTH / 4);

   logic hs_edge, vs_edge;

   lcd_capture_sync_edge u_hs (.clock(clock), .reset(reset), .sig(hsync), .rise(hs_edge));
   lcd_capture_sync_edge u_vs (.clock(clock), .reset(reset), .sig(vsync), .rise(vs_edge));

   lcd_state_e  state, state_nxt;
   logic [7:0]  x, x_nxt, y, y_nxt;
   logic [15:0] ptr, ptr_nxt, line_start, line_start_nxt;
   logic [7:0]  pack, pack_nxt;
   logic        line_bad, line_bad_nxt;
   logic [15:0] a_nxt;
   logic [7:0]  do_nxt;
   logic        wr_n_nxt, done_nxt, lerr_nxt, ferr_nxt;

   logic        take, drop;
   logic [7:0]  x_in, pack_in;
   logic [3:0]  pad_shift;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= SYNC_WAIT;
         x          <= '0;
         y          <= '0;
         ptr        <= FB_BASE;
         line_start <= FB_BASE;
         pack       <= '0;
         line_bad   <= 1'b0;
         fb_A       <= FB_BASE;
         fb_Do      <= '0;
         fb_wr_n    <= 1'b1;
         frame_done <= 1'b0;
         line_err   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state      <= state_nxt;
         x          <= x_nxt;
         y          <= y_nxt;
         ptr        <= ptr_nxt;
         line_start <= line_start_nxt;
         pack       <= pack_nxt;
         line_bad   <= line_bad_nxt;
         fb_A       <= a_nxt;
         fb_Do      <= do_nxt;
         fb_wr_n    <= wr_n_nxt;
         frame_done <= done_nxt;
         line_err   <= lerr_nxt;
         frame_err  <= ferr_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      x_nxt          = x;
      y_nxt          = y;
      ptr_nxt        = ptr;
      line_start_nxt = line_start;
      pack_nxt       = pack;
      line_bad_nxt   = line_bad;
      a_nxt          = fb_A;
      do_nxt         = fb_Do;
      wr_n_nxt       = 1'b1;
      done_nxt       = 1'b0;
      lerr_nxt       = 1'b0;
      ferr_nxt       = 1'b0;

      // Pixel accepted this cycle is folded in before any hsync handling, so a
      // latch coinciding with hsync belongs to the line being closed.
      take      = (state == ACTIVE) && pixel_latch && (x < WIDTH_X);
      drop      = (state == ACTIVE) && pixel_latch && (x >= WIDTH_X);
      x_in      = take ? x + 8'd1 : x;
      pack_in   = take ? {pack[5:0], pixel_data} : pack;
      pad_shift = 4'd8 - {1'b0, x_in[1:0], 1'b0};

      if (vs_edge) begin
         // vsync takes priority over a coincident hsync; no partial flush.
         if (state != SYNC_WAIT) begin
            if (y == HEIGHT_Y) done_nxt = 1'b1;
            else               ferr_nxt = 1'b1;
         end
         x_nxt          = '0;
         y_nxt          = '0;
         ptr_nxt        = FB_BASE;
         line_start_nxt = FB_BASE;
         pack_nxt       = '0;
         line_bad_nxt   = 1'b0;
         state_nxt      = ACTIVE;
      end else if (state == ACTIVE) begin
         x_nxt    = x_in;
         pack_nxt = pack_in;
         if (drop) line_bad_nxt = 1'b1;
         if (take && (x_in[1:0] == 2'd0)) begin
            a_nxt    = ptr;
            do_nxt   = pack_in;
            wr_n_nxt = 1'b0;
            ptr_nxt  = ptr + 16'd1;
         end
         if (hs_edge) begin
            if (x_in[1:0] != 2'd0) begin
               a_nxt    = ptr;
               do_nxt   = pack_in << pad_shift;
               wr_n_nxt = 1'b0;
            end
            if ((x_in != WIDTH_X) || line_bad || drop) lerr_nxt = 1'b1;
            // Next line start is accumulated rather than multiplied out.
            line_start_nxt = line_start + LINE_B;
            ptr_nxt        = line_start + LINE_B;
            x_nxt          = '0;
            y_nxt          = y + 8'd1;
            pack_nxt       = '0;
            line_bad_nxt   = 1'b0;
            if (y + 8'd1 == HEIGHT_Y) state_nxt = BLANK;
         end
      end
   end

   assign fb_cs_n  = fb_wr_n;
   assign cur_line = y;

endmodule

// File: tb/tb_lcd_capture.sv
module tb_lcd_capture;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  pixel_data = 2'd0;
   logic        pixel_latch = 1'b0;
   logic        hsync = 1'b0;
   logic        vsync = 1'b0;
   logic [15:0] fb_A;
   logic [7:0]  fb_Do;
   logic        fb_wr_n, fb_cs_n, frame_done, line_err, frame_err;
   logic [7:0]  cur_line;

   lcd_capture #(.WIDTH(160), .HEIGHT(144), .FB_BASE(16'h0000)) dut (
      .clock(clock), .reset(reset), .pixel_data(pixel_data), .pixel_latch(pixel_latch),
      .hsync(hsync), .vsync(vsync), .fb_A(fb_A), .fb_Do(fb_Do), .fb_wr_n(fb_wr_n),
      .fb_cs_n(fb_cs_n), .frame_done(frame_done), .line_err(line_err),
      .frame_err(frame_err), .cur_line(cur_line)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t         exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          n_done = 0, n_lerr = 0, n_ferr = 0, n_writes = 0;
   logic [15:0] last_addr = '0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every write strobe and counts pulses.
   always @(negedge clock) begin
      if (fb_wr_n === 1'b0) begin
         wr_t e;
         n_writes++;
         last_addr = fb_A;
         check("cs_n_eq_wr_n", int'(fb_cs_n), 0);
         if (exp_q.size() == 0) begin
            check("unexpected_write_addr", int'(fb_A), -1);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", int'(fb_A), int'(e.a));
            check("write_data", int'(fb_Do), int'(e.d));
         end
      end
      if (frame_done === 1'b1) n_done++;
      if (line_err === 1'b1)   n_lerr++;
      if (frame_err === 1'b1)  n_ferr++;
   end

   task automatic cyc(input logic l, input logic [1:0] p, input logic h, input logic v);
      pixel_latch = l;
      pixel_data  = p;
      hsync       = h;
      vsync       = v;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic hs_pulse();
      cyc(1'b0, 2'd0, 1'b1, 1'b0);
      cyc(1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic vs_pulse();
      cyc(1'b0, 2'd0, 1'b0, 1'b1);
      cyc(1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   task automatic push(input logic [15:0] a, input logic [7:0] d);
      wr_t e;
      e.a = a;
      e.d = d;
      exp_q.push_back(e);
   endtask

   // n latches with pixel = x%4; every complete group within 160 is 8'h1B.
   task automatic send_line(input int n, input logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         if ((i % 4 == 3) && (i < 160)) push(base + 16'(i / 4), 8'h1B);
         cyc(1'b1, 2'(i % 4), 1'b0, 1'b0);
      end
   endtask

   task automatic clear_counts();
      n_done = 0;
      n_lerr = 0;
      n_ferr = 0;
   endtask

   initial begin
      reset = 1'b1;
      idle(3);
      check("reset_wr_n", int'(fb_wr_n), 1);
      check("reset_cs_n", int'(fb_cs_n), 1);
      check("reset_fb_A", int'(fb_A), 0);
      check("reset_fb_Do", int'(fb_Do), 0);
      check("reset_cur_line", int'(cur_line), 0);
      check("reset_pulses", int'({frame_done, line_err, frame_err}), 0);
      reset = 1'b0;

      // Pixels and hsync before any vsync are discarded.
      clear_counts();
      for (int i = 0; i < 8; i++) cyc(1'b1, 2'd3, 1'b0, 1'b0);
      hs_pulse();
      idle(3);
      check("presync_writes", n_writes, 0);
      check("presync_lerr", n_lerr, 0);

      // Full well-formed frame.
      clear_counts();
      n_writes = 0;
      vs_pulse();
      for (int y = 0; y < 144; y++) begin
         send_line(160, 16'(y * 40));
         hs_pulse();
      end
      idle(3);
      check("full_cur_line", int'(cur_line), 144);
      vs_pulse();
      idle(3);
      check("full_writes", n_writes, 5760);
      check("full_last_addr", int'(last_addr), 16'h167F);
      check("full_frame_done", n_done, 1);
      check("full_frame_err", n_ferr, 0);
      check("full_line_err", n_lerr, 0);
      check("full_queue_empty", exp_q.size(), 0);

      // Short line of six 2'b11 pixels, then a normal line.
      clear_counts();
      push(16'd0, 8'hFF);
      push(16'd1, 8'hF0);
      for (int i = 0; i < 6; i++) cyc(1'b1, 2'd3, 1'b0, 1'b0);
      hs_pulse();
      idle(2);
      check("short_line_err", n_lerr, 1);
      send_line(160, 16'd40);
      hs_pulse();
      idle(2);
      check("after_short_line_err", n_lerr, 1);

      // Long line: 163 latches, only 40 writes.
      clear_counts();
      send_line(163, 16'd80);
      hs_pulse();
      idle(2);
      check("long_line_err", n_lerr, 1);
      check("long_cur_line", int'(cur_line), 3);
      check("long_queue_empty", exp_q.size(), 0);

      // Early vsync after 10 lines.
      clear_counts();
      for (int y = 3; y < 10; y++) begin
         send_line(160, 16'(y * 40));
         hs_pulse();
      end
      check("early_cur_line", int'(cur_line), 10);
      vs_pulse();
      idle(2);
      check("early_frame_err", n_ferr, 1);
      check("early_frame_done", n_done, 0);

      // First byte of new frame at FB_BASE; last pixel lands with hsync.
      clear_counts();
      push(16'd0, 8'hE4);
      cyc(1'b1, 2'd3, 1'b0, 1'b0);
      cyc(1'b1, 2'd2, 1'b0, 1'b0);
      cyc(1'b1, 2'd1, 1'b0, 1'b0);
      cyc(1'b1, 2'd0, 1'b0, 1'b0);
      for (int i = 4; i < 159; i++) begin
         if (i % 4 == 3) push(16'(i / 4), 8'h1B);
         cyc(1'b1, 2'(i % 4), 1'b0, 1'b0);
      end
      push(16'd39, 8'h1B);
      cyc(1'b1, 2'd3, 1'b1, 1'b0);
      idle(3);
      check("latch_hsync_line_err", n_lerr, 0);
      check("latch_hsync_cur_line", int'(cur_line), 1);
      check("latch_hsync_queue", exp_q.size(), 0);

      // hsync and vsync together: vsync wins, no flush of the 2 pending pixels.
      clear_counts();
      cyc(1'b1, 2'd2, 1'b0, 1'b0);
      cyc(1'b1, 2'd2, 1'b0, 1'b0);
      cyc(1'b0, 2'd0, 1'b1, 1'b1);
      idle(2);
      check("hv_frame_err", n_ferr, 1);
      check("hv_line_err", n_lerr, 0);
      check("hv_frame_done", n_done, 0);
      check("hv_cur_line", int'(cur_line), 0);
      push(16'd0, 8'h55);
      for (int i = 0; i < 4; i++) cyc(1'b1, 2'd1, 1'b0, 1'b0);
      idle(2);
      check("hv_queue_empty", exp_q.size(), 0);

      // Reset coinciding with a group-completing latch drops the write.
      vs_pulse();
      for (int i = 0; i < 3; i++) cyc(1'b1, 2'd3, 1'b0, 1'b0);
      reset = 1'b1;
      cyc(1'b1, 2'd3, 1'b0, 1'b0);
      idle(1);
      reset = 1'b0;
      idle(1);
      clear_counts();
      n_writes = 0;
      check("midreset_wr_n", int'(fb_wr_n), 1);
      check("midreset_cur_line", int'(cur_line), 0);
      for (int i = 0; i < 8; i++) cyc(1'b1, 2'd2, 1'b0, 1'b0);
      hs_pulse();
      idle(2);
      check("midreset_no_writes", n_writes, 0);
      vs_pulse();
      idle(1);
      check("midreset_vs_pulses", n_done + n_ferr, 0);
      send_line(4, 16'd0);
      idle(3);
      check("midreset_resume_writes", n_writes, 1);
      check("final_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
